// File: rtl/vec_normalize_seq.sv
// vec_normalize_seq
//
// Sequential vector normaliser. Takes a signed DIMS-component integer
// vector and an unsigned target length D and returns every component
// scaled so the vector length becomes D:
//     out_c = sign(c) * floor(|c| * D / floor(sqrt(sum c^2)))
// The magnitude comes from a bit-pair integer square root (one root bit
// per cycle, W cycles). The components then go through a single shared
// restoring divider (one quotient bit per cycle, W+DW-1 cycles each).
// Latency from the accept edge to out_valid is always
// 1 + W + DIMS*(W+DW-1) edges, whatever the data.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input vector / length present
//   in_ready   block idle and able to accept (0 while rst_n is low)
//   in_vec     packed signed components, x in the MSB field
//   in_d       unsigned target length D
//   out_valid  result present, held until out_ready
//   out_ready  consumer accepts the result
//   out_vec    normalised components, same packing as in_vec
//   out_mag    floor(sqrt(sum of squares))
//   out_zero   input was the zero vector
module vec_normalize_seq #(
    parameter int W    = 11,
    parameter int DW   = 8,
    parameter int DIMS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIMS*W-1:0]   in_vec,
    input  logic [DW-1:0]       in_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIMS*W-1:0]   out_vec,
    output logic [W-1:0]        out_mag,
    output logic                out_zero
);

    // K: numerator width |c|*D, also the quotient-bit count per component.
    localparam int K  = W + DW - 1;
    localparam int SW = 2 * W;
    localparam int CW = $clog2(K);
    localparam int PW = $clog2(DIMS + 1);

    typedef enum logic [1:0] {IDLE, SQRT, DIV, DONE} state_t;

    // Unsigned magnitude. The most negative value maps to 2^(W-1) and
    // does not wrap, because the result is read as unsigned.
    function automatic logic [W-1:0] abs_mag(input logic signed [W-1:0] c);
        return c[W-1] ? (~c + 1'b1) : c;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic neg, input logic [W-1:0] q);
        return neg ? (~q + 1'b1) : q;
    endfunction

    // Component idx (0 = x) of a packed vector. Out-of-range indices return 0.
    function automatic logic signed [W-1:0] get_comp(input logic [DIMS*W-1:0] v,
                                                     input logic [PW-1:0] idx);
        logic signed [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIMS; i++) begin
            if (idx == PW'(i)) r = v[(DIMS-1-i)*W +: W];
        end
        return r;
    endfunction

    // The sum of squares is below 3*2^(2W-2) < 2^(2W), so 2W bits hold it
    // and the root stays below 2^W.
    function automatic logic [SW-1:0] sum_sq(input logic [DIMS*W-1:0] v);
        logic [SW-1:0] acc;
        logic [W-1:0]  a;
        acc = '0;
        for (int i = 0; i < DIMS; i++) begin
            a   = abs_mag(v[i*W +: W]);
            acc = acc + SW'(a) * SW'(a);
        end
        return acc;
    endfunction

    state_t               state_q;
    logic [DIMS*W-1:0]    vec_q;
    logic [DW-1:0]        d_q;
    logic [SW-1:0]        s_q;        // radicand, consumed two bits per cycle
    logic [W:0]           sq_r_q;     // root remainder
    logic [W-1:0]         root_q;     // partial root; the magnitude during DIV
    logic [W-1:0]         div_r_q;    // divider remainder, always < magnitude
    logic [W-1:0]         div_q_q;    // partial quotient
    logic [CW-1:0]        cnt_q;
    logic [PW-1:0]        comp_q;
    logic [DIMS*W-1:0]    res_q;
    logic                 out_valid_q;
    logic [DIMS*W-1:0]    out_vec_q;
    logic [W-1:0]         out_mag_q;
    logic                 out_zero_q;

    logic [W+2:0]         sq_rt;
    logic [W+2:0]         sq_trial;
    logic                 sq_ge;
    logic [W:0]           sq_r_d;
    logic [W-1:0]         root_d;
    logic signed [W-1:0]  cur_c;
    logic [K-1:0]         num;
    logic                 nbit;
    logic [W:0]           div_rt;
    logic                 div_ge;
    logic [W-1:0]         div_r_d;
    logic [W-1:0]         div_q_d;
    logic [W-1:0]         res_val;

    always_comb begin
        // Square-root step: bring down the next two radicand bits and try
        // to subtract 4*root + 1.
        sq_rt    = {sq_r_q, s_q[SW-1 -: 2]};
        sq_trial = {1'b0, root_q, 2'b01};
        sq_ge    = (sq_rt >= sq_trial);
        sq_r_d   = sq_ge ? (W+1)'(sq_rt - sq_trial) : (W+1)'(sq_rt);
        root_d   = {root_q[W-2:0], sq_ge};

        // Divider step: numerator bits are taken MSB first, straight from
        // the stored component, so nothing has to be preloaded.
        cur_c    = get_comp(vec_q, comp_q);
        num      = K'(abs_mag(cur_c)) * K'(d_q);
        nbit     = num[CW'(K-1) - cnt_q];
        div_rt   = {div_r_q, nbit};
        div_ge   = (div_rt >= {1'b0, root_q});
        div_r_d  = div_ge ? W'(div_rt - {1'b0, root_q}) : W'(div_rt);
        // The quotient never exceeds D < 2^(W-1), so shifting out the top
        // bit of the partial quotient loses nothing.
        div_q_d  = {div_q_q[W-2:0], div_ge};

        // A zero magnitude bypasses the divider result.
        res_val  = (root_q == '0) ? '0 : apply_sign(cur_c[W-1], div_q_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            d_q         <= '0;
            s_q         <= '0;
            sq_r_q      <= '0;
            root_q      <= '0;
            div_r_q     <= '0;
            div_q_q     <= '0;
            cnt_q       <= '0;
            comp_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_mag_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        vec_q   <= in_vec;
                        d_q     <= in_d;
                        s_q     <= sum_sq(in_vec);
                        sq_r_q  <= '0;
                        root_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= SQRT;
                    end
                end
                SQRT: begin
                    s_q    <= {s_q[SW-3:0], 2'b00};
                    sq_r_q <= sq_r_d;
                    root_q <= root_d;
                    if (cnt_q == CW'(W-1)) begin
                        cnt_q   <= '0;
                        comp_q  <= '0;
                        div_r_q <= '0;
                        div_q_q <= '0;
                        state_q <= DIV;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    if (comp_q == PW'(DIMS)) begin
                        // All components done: publish the result.
                        out_vec_q   <= res_q;
                        out_mag_q   <= root_q;
                        out_zero_q  <= (root_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (cnt_q == CW'(K-1)) begin
                        for (int i = 0; i < DIMS; i++) begin
                            if (comp_q == PW'(i)) res_q[(DIMS-1-i)*W +: W] <= res_val;
                        end
                        div_r_q <= '0;
                        div_q_q <= '0;
                        cnt_q   <= '0;
                        comp_q  <= comp_q + 1'b1;
                    end else begin
                        div_r_q <= div_r_d;
                        div_q_q <= div_q_d;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so that in_ready reads 0 during reset and 1 as soon
    // as reset is released.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_mag   = out_mag_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_vec_normalize_seq.sv
module tb_vec_normalize_seq;
    localparam int W  = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              iv2, ir2, ov2, or2, oz2;
    logic [2*W-1:0]    ivec2, ovec2;
    logic [DW-1:0]     id2;
    logic [W-1:0]      omag2;

    logic              iv3, ir3, ov3, or3, oz3;
    logic [3*W-1:0]    ivec3, ovec3;
    logic [DW-1:0]     id3;
    logic [W-1:0]      omag3;

    vec_normalize_seq #(.W(W), .DW(DW), .DIMS(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2), .in_vec(ivec2), .in_d(id2),
        .out_valid(ov2), .out_ready(or2), .out_vec(ovec2),
        .out_mag(omag2), .out_zero(oz2)
    );

    vec_normalize_seq #(.W(W), .DW(DW), .DIMS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv3), .in_ready(ir3), .in_vec(ivec3), .in_d(id3),
        .out_valid(ov3), .out_ready(or3), .out_vec(ovec3),
        .out_mag(omag3), .out_zero(oz3)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic signed [W-1:0] x, y;
        logic [DW-1:0]       d;
        logic signed [W-1:0] ex, ey;
        logic [W-1:0]        emag;
        logic                ezero;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One DIMS=2 transaction: accept, measure latency, check the result.
    task automatic run2(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        input logic [DW-1:0] d, input logic signed [W-1:0] ex,
                        input logic signed [W-1:0] ey, input logic [W-1:0] emag,
                        input logic ezero);
        int n;
        logic signed [W-1:0] gx, gy;
        @(negedge clk);
        chk("in_ready_before_accept", ir2, 1);
        iv2 = 1'b1; ivec2 = {x, y}; id2 = d;
        @(posedge clk); #1;
        iv2 = 1'b0;
        n = 0;
        while (!ov2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency2", n, 48);
        gx = ovec2[2*W-1:W];
        gy = ovec2[W-1:0];
        chk("out_x", gx, ex);
        chk("out_y", gy, ey);
        chk("out_mag", omag2, emag);
        chk("out_zero", oz2, ezero);
    endtask

    task automatic hs2();
        @(negedge clk);
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
        chk("out_valid_after_hs", ov2, 0);
        chk("in_ready_after_hs", ir2, 1);
    endtask

    task automatic run3(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        input logic signed [W-1:0] z, input logic [DW-1:0] d,
                        input logic signed [W-1:0] ex, input logic signed [W-1:0] ey,
                        input logic signed [W-1:0] ez, input logic [W-1:0] emag,
                        input logic ezero);
        int n;
        logic signed [W-1:0] gx, gy, gz;
        @(negedge clk);
        chk("in_ready3_before_accept", ir3, 1);
        iv3 = 1'b1; ivec3 = {x, y, z}; id3 = d;
        @(posedge clk); #1;
        iv3 = 1'b0;
        n = 0;
        while (!ov3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency3", n, 66);
        gx = ovec3[3*W-1:2*W];
        gy = ovec3[2*W-1:W];
        gz = ovec3[W-1:0];
        chk("out3_x", gx, ex);
        chk("out3_y", gy, ey);
        chk("out3_z", gz, ez);
        chk("out3_mag", omag3, emag);
        chk("out3_zero", oz3, ezero);
        @(negedge clk);
        or3 = 1'b1;
        @(posedge clk); #1;
        or3 = 1'b0;
        chk("out3_valid_after_hs", ov3, 0);
        chk("in_ready3_after_hs", ir3, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int quiet;
        iv2 = 0; or2 = 0; ivec2 = '0; id2 = '0;
        iv3 = 0; or3 = 0; ivec3 = '0; id3 = '0;

        //        x      y    d     ex    ey   mag   zero
        tbl[0] = '{   3,    4, 100,   60,   80,    5, 1'b0};
        tbl[1] = '{  -3,    4, 100,  -60,   80,    5, 1'b0};
        tbl[2] = '{1023,-1024, 255,  180, -180, 1447, 1'b0};
        tbl[3] = '{   0,    0, 200,    0,    0,    0, 1'b1};
        tbl[4] = '{-1024,   0, 255, -255,    0, 1024, 1'b0};
        tbl[5] = '{   3,    4,   0,    0,    0,    5, 1'b0};
        tbl[6] = '{   1,    1, 100,  100,  100,    1, 1'b0};
        tbl[7] = '{-1024,-1024,255, -180, -180, 1448, 1'b0};
        tbl[8] = '{   5,    0,   1,    1,    0,    5, 1'b0};
        tbl[9] = '{   0,   -7,  50,    0,  -50,    7, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        #3;
        chk("rst_in_ready", ir2, 0);
        chk("rst_out_valid", ov2, 0);
        chk("rst_out_vec", ovec2, 0);
        chk("rst_out_mag", omag2, 0);
        chk("rst_out_zero", oz2, 0);
        chk("rst_in_ready3", ir3, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", ir2, 1);
        chk("in_ready3_after_reset", ir3, 1);

        // Table of directed vectors
        for (int i = 0; i < 10; i++) begin
            run2(tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].ex, tbl[i].ey,
                 tbl[i].emag, tbl[i].ezero);
            hs2();
        end

        // Three-component instance
        run3(2, 3, 6, 14, 4, 6, 12, 7, 1'b0);
        run3(-1024, 0, 0, 255, -255, 0, 0, 1024, 1'b0);
        run3(0, 0, 0, 99, 0, 0, 0, 0, 1'b1);

        // Backpressure: result held for 10 cycles, stray in_valid ignored
        run2(6, 8, 7, 4, 5, 10, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                iv2 = 1'b1; ivec2 = {11'sd1, 11'sd1}; id2 = 8'd9;
            end else begin
                iv2 = 1'b0;
            end
            chk("hold_in_ready", ir2, 0);
            chk("hold_out_valid", ov2, 1);
            chk("hold_out_vec", ovec2, {11'sd4, 11'sd5});
            chk("hold_out_mag", omag2, 10);
        end
        @(negedge clk);
        iv2 = 1'b0;
        hs2();
        quiet = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (ov2) quiet++;
        end
        chk("no_result_from_ignored_pulse", quiet, 0);

        // Reset in the middle of a transaction
        @(negedge clk);
        iv2 = 1'b1; ivec2 = {11'sd1023, -11'sd1024}; id2 = 8'd255;
        @(posedge clk); #1;
        iv2 = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", ir2, 0);
        chk("midrst_out_valid", ov2, 0);
        chk("midrst_out_vec", ovec2, 0);
        chk("midrst_out_mag", omag2, 0);
        chk("midrst_out_zero", oz2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready_release", ir2, 1);
        quiet = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (ov2) quiet++;
        end
        chk("midrst_no_out_valid", quiet, 0);
        run2(3, 4, 100, 60, 80, 5, 1'b0);
        hs2();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
